// File: rtl/video_timing_pattern.sv
// ============================================================================
// video_timing_pattern
// ----------------------------------------------------------------------------
// Purpose
//   Parametrised raster timing generator with a built-in test pattern source.
//   It produces blank/hsync/vsync, position and RGB for the HDMI video
//   encoder. Everything leaving the block is registered from one shared
//   counter state, so sync, blank, position and pixel data never skew
//   relative to each other.
//
//   Line layout  : active | front porch | sync | back porch
//   Frame layout : active | front porch | sync | back porch  (whole lines)
//
// Optional feature (compile-time macro)
//   FRAME_COUNT_EN : adds the 16-bit frame_cnt output and makes the checker
//                    pattern scroll one pixel to the left per frame.
//                    Leave it undefined for the plain static-checker build.
//
// Ports
//   clk          in   pixel clock
//   reset        in   synchronous reset, active-low
//   enable       in   advance the raster; low freezes counters and outputs
//   mode         in   pattern select: 0 bars, 1 checker, 2 grey ramp, 3 solid
//   solid_rgb    in   {R,G,B} used by the solid pattern
//   blank        out  high outside the active area
//   hsync        out  horizontal sync, active level HS_POL
//   vsync        out  vertical sync, active level VS_POL
//   line_start   out  one-cycle pulse with the first pixel of every line
//   frame_start  out  one-cycle pulse with pixel (0,0)
//   xpos, ypos   out  column / line of the pixel currently presented
//   red/green/blue out pixel data, forced to zero while blanked
//   frame_cnt    out  (FRAME_COUNT_EN only) index of the frame being output
// ============================================================================

module video_timing_pattern #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 12,
    parameter int BPC      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [3*BPC-1:0] solid_rgb,
    output logic             blank,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [CW-1:0]    xpos,
    output logic [CW-1:0]    ypos,
    output logic [BPC-1:0]   red,
    output logic [BPC-1:0]   green,
    output logic [BPC-1:0]   blue
`ifdef FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived timing constants, all sized to the counter width
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Bar width; the final bar soaks up whatever H_ACTIVE/8 leaves over.
    localparam int BW = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] BW_LAST   = CW'(BW - 1);

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    localparam logic [1:0] MODE_BARS    = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_RAMP    = 2'd2;
    localparam logic [1:0] MODE_SOLID   = 2'd3;

    localparam logic [2:0] BAR_LAST = 3'd7;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0]  hCnt_q, hCnt_d;
    logic [CW-1:0]  vCnt_q, vCnt_d;
    logic [CW-1:0]  barCnt_q, barCnt_d;
    logic [2:0]     barIdx_q, barIdx_d;
    logic [1:0]     mode_q, mode_d;

    logic           blank_q, blank_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           lineStart_q, lineStart_d;
    logic           frameStart_q, frameStart_d;
    logic [CW-1:0]  xpos_q, xpos_d;
    logic [CW-1:0]  ypos_q, ypos_d;
    logic [BPC-1:0] red_q, red_d;
    logic [BPC-1:0] green_q, green_d;
    logic [BPC-1:0] blue_q, blue_d;

    // ------------------------------------------------------------------------
    // Position decode for the pixel the next enabled edge will present
    // ------------------------------------------------------------------------
    logic          atLineStart;
    logic          atOrigin;
    logic          hActive;
    logic          vActive;
    logic          active;
    logic          hsyncOn;
    logic          vsyncOn;
    logic [1:0]    effMode;
    logic [2:0]    barIdxCur;
    logic [CW-1:0] barCntCur;
    logic          checkerBit;
    logic          checkerWhite;

    assign atLineStart = (hCnt_q == '0);
    assign atOrigin    = atLineStart && (vCnt_q == '0);
    assign hActive     = (hCnt_q < H_ACT_END);
    assign vActive     = (vCnt_q < V_ACT_END);
    assign active      = hActive && vActive;
    assign hsyncOn     = (hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST);
    assign vsyncOn     = (vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST);

    // The mode sampled at pixel (0,0) already governs pixel (0,0) itself, so
    // a whole frame is always drawn in a single pattern.
    assign effMode = atOrigin ? mode : mode_q;

    // Bar state is forced clear on the first pixel of each line, so it never
    // depends on what happened during the previous line's blanking.
    assign barIdxCur = atLineStart ? 3'd0 : barIdx_q;
    assign barCntCur = atLineStart ? '0   : barCnt_q;

    // ------------------------------------------------------------------------
    // Optional frame counter; also moves the checker's column phase
    // ------------------------------------------------------------------------
`ifdef FRAME_COUNT_EN
    logic [15:0] framesSeen_q, framesSeen_d;
    logic [15:0] frameCnt_q, frameCnt_d;
    logic [15:0] frameIdx;

    // framesSeen counts frames started so far; frame_cnt shows the index of
    // the frame now on screen, so the first frame after reset reads 0.
    always_comb begin
        frameIdx     = atOrigin ? framesSeen_q : frameCnt_q;
        framesSeen_d = framesSeen_q;
        frameCnt_d   = frameCnt_q;
        if (atOrigin) begin
            framesSeen_d = framesSeen_q + 16'd1;
            frameCnt_d   = framesSeen_q;
        end
    end

    // Only bit 5 of the shifted column matters for a 32-pixel tile.
    assign checkerBit = 1'((hCnt_q + CW'(frameIdx)) >> 5);

    // Frame counters share the raster's reset and freeze behaviour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            framesSeen_q <= '0;
            frameCnt_q   <= '0;
        end else if (enable) begin
            framesSeen_q <= framesSeen_d;
            frameCnt_q   <= frameCnt_d;
        end
    end

    assign frame_cnt = frameCnt_q;
`else
    assign checkerBit = hCnt_q[5];
`endif

    assign checkerWhite = ~(checkerBit ^ vCnt_q[5]);

    // ------------------------------------------------------------------------
    // Raster counters: hcnt wraps at the end of the line and carries into
    // vcnt, which wraps at the end of the frame.
    // ------------------------------------------------------------------------
    always_comb begin
        hCnt_d = hCnt_q + ONE;
        vCnt_d = vCnt_q;
        if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            if (vCnt_q == V_LAST) begin
                vCnt_d = '0;
            end else begin
                vCnt_d = vCnt_q + ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Colour-bar stepping: a width counter ticks every pixel and bumps the
    // bar index every BW pixels, stopping at the last bar.
    // ------------------------------------------------------------------------
    always_comb begin
        barCnt_d = barCntCur + ONE;
        barIdx_d = barIdxCur;
        if (barCntCur == BW_LAST) begin
            barCnt_d = '0;
            if (barIdxCur != BAR_LAST) begin
                barIdx_d = barIdxCur + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pattern source: RGB for the current pixel, zero outside active video.
    // Bar colours fall out of the index bits directly:
    // white, yellow, cyan, green, magenta, red, blue, black.
    // ------------------------------------------------------------------------
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (active) begin
            case (effMode)
                MODE_BARS: begin
                    red_d   = {BPC{~barIdxCur[1]}};
                    green_d = {BPC{~barIdxCur[2]}};
                    blue_d  = {BPC{~barIdxCur[0]}};
                end
                MODE_CHECKER: begin
                    red_d   = {BPC{checkerWhite}};
                    green_d = {BPC{checkerWhite}};
                    blue_d  = {BPC{checkerWhite}};
                end
                MODE_RAMP: begin
                    red_d   = BPC'(hCnt_q);
                    green_d = BPC'(hCnt_q);
                    blue_d  = BPC'(hCnt_q);
                end
                default: begin
                    red_d   = solid_rgb[3*BPC-1 -: BPC];
                    green_d = solid_rgb[2*BPC-1 -: BPC];
                    blue_d  = solid_rgb[BPC-1   -: BPC];
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Timing outputs for the current pixel and the frame-synchronous mode
    // latch.
    // ------------------------------------------------------------------------
    always_comb begin
        blank_d      = ~active;
        hsync_d      = hsyncOn ? HS_ON : ~HS_ON;
        vsync_d      = vsyncOn ? VS_ON : ~VS_ON;
        lineStart_d  = atLineStart;
        frameStart_d = atOrigin;
        xpos_d       = hCnt_q;
        ypos_d       = vCnt_q;
        mode_d       = effMode;
    end

    // ------------------------------------------------------------------------
    // Single register stage. An enabled edge presents the pixel at the
    // current counters and steps the counters; with enable low everything,
    // including the one-cycle pulses, simply holds. Reset parks the raster
    // at (0,0) so the very next enabled edge starts a fresh frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            barCnt_q     <= '0;
            barIdx_q     <= '0;
            mode_q       <= '0;
            blank_q      <= 1'b1;
            hsync_q      <= ~HS_ON;
            vsync_q      <= ~VS_ON;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else if (enable) begin
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            barCnt_q     <= barCnt_d;
            barIdx_q     <= barIdx_d;
            mode_q       <= mode_d;
            blank_q      <= blank_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
        end
    end

    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: tb/tb_video_timing_pattern.sv
// ============================================================================
// tb_video_timing_pattern
// ----------------------------------------------------------------------------
// Two instances share one set of inputs:
//   A : 16x8 raster (8/2/3/3, 4/1/2/1), bar width 1
//   B : 44x6 raster (36/2/3/3, 3/1/1/1), bar width 4 with a wide last bar and
//       a checker tile edge at x=32
// An ideal-pixel model tracks each raster and is compared against both
// instances every clock; directed literal checks pin key points.
// ============================================================================

module tb_video_timing_pattern;

    typedef struct packed {
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] solidRgb;

    logic        blankA, hsA, vsA, lsA, fsA;
    logic [11:0] xA, yA;
    logic [7:0]  rA, gA, bA;
    logic        blankB, hsB, vsB, lsB, fsB;
    logic [11:0] xB, yB;
    logic [7:0]  rB, gB, bB;

    pix_t actA, actB;
    assign actA = {blankA, hsA, vsA, lsA, fsA, xA, yA, rA, gA, bA};
    assign actB = {blankB, hsB, vsB, lsB, fsB, xB, yB, rB, gB, bB};

    int vectors     = 0;
    int miscompares = 0;
    int cyc;
    int hsLow, vsLow, fsCount;

    always #5 clk = ~clk;

    video_timing_pattern #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CW(12), .BPC(8)
    ) dutA (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .solid_rgb(solidRgb),
        .blank(blankA), .hsync(hsA), .vsync(vsA),
        .line_start(lsA), .frame_start(fsA),
        .xpos(xA), .ypos(yA),
        .red(rA), .green(gA), .blue(bA)
    );

    video_timing_pattern #(
        .H_ACTIVE(36), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CW(12), .BPC(8)
    ) dutB (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .solid_rgb(solidRgb),
        .blank(blankB), .hsync(hsB), .vsync(vsB),
        .line_start(lsB), .frame_start(fsB),
        .xpos(xB), .ypos(yB),
        .red(rB), .green(gB), .blue(bB)
    );

    // ------------------------------------------------------------------------
    // Ideal model: geometry per instance and a pure function of (x, y, mode)
    // ------------------------------------------------------------------------
    int gHA[2] = '{8, 36};
    int gHF[2] = '{2, 2};
    int gHS[2] = '{3, 3};
    int gHB[2] = '{3, 3};
    int gVA[2] = '{4, 3};
    int gVF[2] = '{1, 1};
    int gVS[2] = '{2, 1};
    int gVB[2] = '{1, 1};

    function automatic logic [2:0] barColour(int bar);
        case (bar)
            0: return 3'b111;   // white
            1: return 3'b110;   // yellow
            2: return 3'b011;   // cyan
            3: return 3'b010;   // green
            4: return 3'b101;   // magenta
            5: return 3'b100;   // red
            6: return 3'b001;   // blue
            default: return 3'b000; // black
        endcase
    endfunction

    function automatic pix_t idealPixel(int g, int x, int y, logic [1:0] md, logic [23:0] sol);
        pix_t p;
        int bar;
        logic [2:0] c;
        logic [7:0] lvl;
        p.blank = !(x < gHA[g] && y < gVA[g]);
        p.hs = (x >= gHA[g] + gHF[g] && x < gHA[g] + gHF[g] + gHS[g]) ? 1'b0 : 1'b1;
        p.vs = (y >= gVA[g] + gVF[g] && y < gVA[g] + gVF[g] + gVS[g]) ? 1'b0 : 1'b1;
        p.ls = (x == 0);
        p.fs = (x == 0 && y == 0);
        p.x  = 12'(x);
        p.y  = 12'(y);
        p.r  = 8'h00;
        p.g  = 8'h00;
        p.b  = 8'h00;
        if (!p.blank) begin
            case (md)
                2'd0: begin
                    bar = x / (gHA[g] / 8);
                    if (bar > 7) bar = 7;
                    c = barColour(bar);
                    p.r = c[2] ? 8'hFF : 8'h00;
                    p.g = c[1] ? 8'hFF : 8'h00;
                    p.b = c[0] ? 8'hFF : 8'h00;
                end
                2'd1: begin
                    lvl = (((x / 32) + (y / 32)) % 2 == 0) ? 8'hFF : 8'h00;
                    p.r = lvl; p.g = lvl; p.b = lvl;
                end
                2'd2: begin
                    lvl = 8'(x % 256);
                    p.r = lvl; p.g = lvl; p.b = lvl;
                end
                default: {p.r, p.g, p.b} = sol;
            endcase
        end
        return p;
    endfunction

    pix_t resetPix;
    assign resetPix = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 8'd0, 8'd0, 8'd0};

    int         mh[2];
    int         mv[2];
    logic [1:0] fmode[2];
    pix_t       expPix[2];
    bit         modelLive = 0;

    // Advance the model on every clock from the inputs seen at the edge, then
    // compare both instances once their outputs have settled.
    always @(posedge clk) begin
        logic       rS, eS;
        logic [1:0] mS;
        logic [23:0] sS;
        pix_t       act;
        rS = reset;
        eS = enable;
        mS = mode;
        sS = solidRgb;
        for (int g = 0; g < 2; g++) begin
            if (!rS) begin
                mh[g] = 0; mv[g] = 0; fmode[g] = 2'd0;
                expPix[g] = resetPix;
            end else if (eS) begin
                if (mh[g] == 0 && mv[g] == 0) fmode[g] = mS;
                expPix[g] = idealPixel(g, mh[g], mv[g], fmode[g], sS);
                mh[g]++;
                if (mh[g] == gHA[g] + gHF[g] + gHS[g] + gHB[g]) begin
                    mh[g] = 0;
                    mv[g]++;
                    if (mv[g] == gVA[g] + gVF[g] + gVS[g] + gVB[g]) mv[g] = 0;
                end
            end
        end
        if (!rS) modelLive = 1;
        #1;
        if (modelLive) begin
            for (int g = 0; g < 2; g++) begin
                act = (g == 0) ? actA : actB;
                vectors++;
                if (act !== expPix[g]) begin
                    miscompares++;
                    $display("[TB] FAIL model dut%s t=%0t: got %h, expected %h",
                             (g == 0) ? "A" : "B", $time, act, expPix[g]);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] md);
        reset  = rst;
        enable = en;
        mode   = md;
    endtask

    // One clock; outputs are looked at 1 time unit after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
        if (hsA == 1'b0) hsLow++;
        if (vsA == 1'b0) vsLow++;
        if (fsA == 1'b1) fsCount++;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) stepCycle();
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence; cycle 0 is the first edge after reset release
    // ------------------------------------------------------------------------
    initial begin
        applyStimulus(1'b0, 1'b1, 2'd0);
        solidRgb = 24'h123456;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reset blank", blankA, 1);
        checkOutput("reset hsync", hsA, 1);
        checkOutput("reset vsync", vsA, 1);
        checkOutput("reset frame_start", fsA, 0);
        checkOutput("reset xy", {xA, yA}, 0);
        checkOutput("reset rgb", {rA, gA, bA}, 0);

        applyStimulus(1'b1, 1'b1, 2'd0);
        cyc = -1; hsLow = 0; vsLow = 0; fsCount = 0;

        stepCycle();  // c0
        checkOutput("c0 frame_start", fsA, 1);
        checkOutput("c0 line_start", lsA, 1);
        checkOutput("c0 blank", blankA, 0);
        checkOutput("c0 xy", {xA, yA}, 0);
        checkOutput("c0 rgb", {rA, gA, bA}, 32'hFFFFFF);
        checkOutput("c0 B rgb", {rB, gB, bB}, 32'hFFFFFF);
        stepCycle();  // c1
        checkOutput("c1 xpos", xA, 1);
        checkOutput("c1 rgb yellow", {rA, gA, bA}, 32'hFFFF00);

        runTo(15);
        checkOutput("hsync low count line0", hsLow, 3);
        runTo(27);
        checkOutput("B bar6 blue", {rB, gB, bB}, 32'h0000FF);
        runTo(35);
        checkOutput("B last bar absorbs remainder", {rB, gB, bB}, 32'h000000);

        runTo(39);
        applyStimulus(1'b1, 1'b1, 2'd2);
        runTo(50);
        checkOutput("mid-frame mode ignored", {rA, gA, bA}, 32'h00FFFF);
        runTo(127);
        checkOutput("vsync low count frame", vsLow, 32);
        checkOutput("frame_start once per frame", fsCount, 1);
        runTo(128);
        checkOutput("c128 frame_start", fsA, 1);
        runTo(131);
        checkOutput("ramp x3", {rA, gA, bA}, 32'h030303);

        runTo(133);
        checkOutput("pre-freeze xpos", xA, 5);
        applyStimulus(1'b1, 1'b0, 2'd2);
        repeat (5) begin
            stepCycle();
            checkOutput("frozen xpos", xA, 5);
            checkOutput("frozen rgb", {rA, gA, bA}, 32'h050505);
        end
        applyStimulus(1'b1, 1'b1, 2'd2);
        stepCycle();  // c139
        checkOutput("resume xpos", xA, 6);

        runTo(200);
        applyStimulus(1'b1, 1'b1, 2'd1);
        runTo(260);
        checkOutput("c260 no frame_start", fsA, 0);
        runTo(261);
        checkOutput("c261 frame_start after freeze", fsA, 1);

        runTo(300);
        applyStimulus(1'b1, 1'b1, 2'd3);
        solidRgb = 24'h3C5AF0;
        runTo(389);
        checkOutput("c389 frame_start", fsA, 1);
        checkOutput("solid pixel", {rA, gA, bA}, 32'h3C5AF0);

        runTo(425);
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepCycle();  // c426: reset lands on pixel (5,2)
        checkOutput("mid reset blank", blankA, 1);
        checkOutput("mid reset syncs", {hsA, vsA}, 2'b11);
        checkOutput("mid reset xy", {xA, yA}, 0);
        checkOutput("mid reset rgb", {rA, gA, bA}, 0);
        checkOutput("mid reset pulses", {lsA, fsA}, 0);
        applyStimulus(1'b1, 1'b1, 2'd0);
        stepCycle();  // c427
        checkOutput("post reset frame_start", fsA, 1);
        checkOutput("post reset rgb", {rA, gA, bA}, 32'hFFFFFF);
        checkOutput("post reset B frame_start", fsB, 1);

        for (int k = 0; k < 1200; k++) begin
            applyStimulus(1'b1, (k % 5) != 4, 2'((k / 150) % 4));
            if (k % 50 == 0) solidRgb = 24'h00A5F3 ^ 24'(k * 1237);
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
